// File: rtl/median_disp_pkg.sv
// Shared constants for the streaming 3x3 disparity median stage.
package median_disp_pkg;
    localparam logic MODE_BYPASS = 1'b0;
    localparam logic MODE_MEDIAN = 1'b1;
    localparam logic BORDER_ZERO = 1'b0;
    localparam logic BORDER_REP  = 1'b1;
    localparam int   LATENCY     = 4;
endpackage

// File: rtl/median_disp_stream_if.sv
// Pixel stream in and filtered pixel stream out of the disparity median stage.
interface median_disp_stream_if #(
    parameter int DW  = 16,
    parameter int NCH = 2
);
    // in_valid qualifies din and sof on every clken edge; there is no ready,
    // so the sink must take each out_valid pixel on the edge it is presented.
    logic              sof;
    logic              in_valid;
    logic [NCH*DW-1:0] din;
    logic              out_valid;
    logic [NCH*DW-1:0] dout;
    logic              out_sof;
    logic              out_eol;

    modport master (output sof, in_valid, din, input out_valid, dout, out_sof, out_eol);
    modport slave  (input sof, in_valid, din, output out_valid, dout, out_sof, out_eol);
endinterface

// File: rtl/median_disp_sort9.sv
// Two-stage unsigned median-of-9 network: row sort, then med3 of the row extremes.
module median_disp_sort9 #(
    parameter int DW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clken,
    input  logic [8:0][DW-1:0]  d_i,
    output logic [DW-1:0]       med_o
);
    function automatic logic [DW-1:0] min2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a < b) ? b : a;
    endfunction

    function automatic logic [DW-1:0] med3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    logic [DW-1:0] lo [3];
    logic [DW-1:0] md [3];
    logic [DW-1:0] hi [3];
    logic [DW-1:0] lo_q, md_q, hi_q, med_q;

    always_comb begin
        for (int g = 0; g < 3; g++) begin
            lo[g] = min2(min2(d_i[3*g], d_i[3*g+1]), d_i[3*g+2]);
            md[g] = med3(d_i[3*g], d_i[3*g+1], d_i[3*g+2]);
            hi[g] = max2(max2(d_i[3*g], d_i[3*g+1]), d_i[3*g+2]);
        end
    end

    // Median of 9 = med3(max of row minima, med of row medians, min of row maxima).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo_q  <= '0;
            md_q  <= '0;
            hi_q  <= '0;
            med_q <= '0;
        end else if (clken) begin
            lo_q  <= max2(max2(lo[0], lo[1]), lo[2]);
            md_q  <= med3(md[0], md[1], md[2]);
            hi_q  <= min2(min2(hi[0], hi[1]), hi[2]);
            med_q <= med3(lo_q, md_q, hi_q);
        end
    end

    assign med_o = med_q;
endmodule

// File: rtl/median_disp_stream.sv
// Streaming 3x3 median/bypass filter over NCH disparity channels with a two-line buffer.
module median_disp_stream
    import median_disp_pkg::*;
#(
    parameter int DW   = 16,
    parameter int NCH  = 2,
    parameter int MAXW = 2048,
    parameter int AW   = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clken,
    input  logic [AW-1:0]        width,
    input  logic                 mode,
    input  logic                 border_rep,
    median_disp_stream_if.slave  s
);
    localparam int PW = NCH * DW;

    logic          acc, eol;
    logic [AW-1:0] x_q, x_d, lastx_q, lastx_d, cur_x;
    logic [1:0]    yc_q, yc_d, cur_y;
    logic          mode_q, mode_d, rep_q, rep_d;

    // sof acts on the pixel it arrives with, so frame parameters are taken combinationally.
    always_comb begin
        acc     = clken & s.in_valid;
        cur_x   = s.sof ? '0 : x_q;
        cur_y   = s.sof ? 2'd0 : yc_q;
        lastx_d = s.sof ? ((width == '0) ? '0 : width - AW'(1)) : lastx_q;
        mode_d  = s.sof ? mode : mode_q;
        rep_d   = s.sof ? border_rep : rep_q;
        eol     = (cur_x == lastx_d);
        x_d     = eol ? '0 : cur_x + AW'(1);
        yc_d    = (!eol || cur_y == 2'd2) ? cur_y : cur_y + 2'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q     <= '0;
            yc_q    <= '0;
            lastx_q <= AW'(MAXW - 1);
            mode_q  <= MODE_MEDIAN;
            rep_q   <= BORDER_ZERO;
        end else if (acc) begin
            x_q     <= x_d;
            yc_q    <= yc_d;
            lastx_q <= lastx_d;
            mode_q  <= mode_d;
            rep_q   <= rep_d;
        end
    end

    // Word per column is {row y-2, row y-1}; read-first, then shift the current pixel in.
    logic [2*PW-1:0] mem [MAXW];
    logic [2*PW-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (acc) begin
            rd_q        <= mem[cur_x];
            mem[cur_x]  <= {mem[cur_x][PW-1:0], s.din};
        end
    end

    logic          v1_q, x01_q, rep1_q, mode1_q, sof1_q, eol1_q;
    logic [1:0]    yc1_q;
    logic [PW-1:0] px1_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q    <= 1'b0;
            x01_q   <= 1'b0;
            rep1_q  <= BORDER_ZERO;
            mode1_q <= MODE_MEDIAN;
            sof1_q  <= 1'b0;
            eol1_q  <= 1'b0;
            yc1_q   <= '0;
            px1_q   <= '0;
        end else if (clken) begin
            v1_q    <= s.in_valid;
            x01_q   <= (cur_x == '0);
            rep1_q  <= rep_d;
            mode1_q <= mode_d;
            sof1_q  <= s.in_valid & s.sof;
            eol1_q  <= s.in_valid & eol;
            yc1_q   <= cur_y;
            px1_q   <= s.din;
        end
    end

    // Incoming column per channel, index 0 = row y-2 .. 2 = row y, with row clamping/padding.
    logic [DW-1:0] col [NCH][3];

    always_comb begin
        logic [DW-1:0] px, y1, y2;
        px = '0;
        y1 = '0;
        y2 = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            px = px1_q[ch*DW +: DW];
            y1 = rd_q[ch*DW +: DW];
            y2 = rd_q[PW + ch*DW +: DW];
            col[ch][2] = px;
            case (yc1_q)
                2'd0: begin
                    col[ch][1] = rep1_q ? px : '0;
                    col[ch][0] = rep1_q ? px : '0;
                end
                2'd1: begin
                    col[ch][1] = y1;
                    col[ch][0] = rep1_q ? y1 : '0;
                end
                default: begin
                    col[ch][1] = y1;
                    col[ch][0] = y2;
                end
            endcase
        end
    end

    logic [DW-1:0] win_q [NCH][3][3];
    logic          v2_q, mode2_q, sof2_q, eol2_q;
    logic [PW-1:0] byp2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int ch = 0; ch < NCH; ch++)
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        win_q[ch][r][c] <= '0;
            v2_q    <= 1'b0;
            mode2_q <= MODE_MEDIAN;
            sof2_q  <= 1'b0;
            eol2_q  <= 1'b0;
            byp2_q  <= '0;
        end else if (clken) begin
            v2_q    <= v1_q;
            mode2_q <= mode1_q;
            sof2_q  <= sof1_q;
            eol2_q  <= eol1_q;
            byp2_q  <= px1_q;
            if (v1_q) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    for (int r = 0; r < 3; r++) begin
                        win_q[ch][r][2] <= col[ch][r];
                        if (x01_q) begin
                            win_q[ch][r][1] <= rep1_q ? col[ch][r] : '0;
                            win_q[ch][r][0] <= rep1_q ? col[ch][r] : '0;
                        end else begin
                            win_q[ch][r][1] <= win_q[ch][r][2];
                            win_q[ch][r][0] <= win_q[ch][r][1];
                        end
                    end
                end
            end
        end
    end

    // Bypass feeds nine copies of the centre pixel, so it shares the median latency.
    logic [8:0][DW-1:0] taps [NCH];
    logic [DW-1:0]      med  [NCH];

    always_comb begin
        for (int ch = 0; ch < NCH; ch++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    taps[ch][r*3+c] = (mode2_q == MODE_MEDIAN) ? win_q[ch][r][c]
                                                               : byp2_q[ch*DW +: DW];
    end

    for (genvar ch = 0; ch < NCH; ch++) begin : g_sort
        median_disp_sort9 #(.DW(DW)) u_sort (
            .clk   (clk),
            .rst   (rst),
            .clken (clken),
            .d_i   (taps[ch]),
            .med_o (med[ch])
        );
    end

    logic v3_q, sof3_q, eol3_q, v4_q, sof4_q, eol4_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v3_q   <= 1'b0;
            sof3_q <= 1'b0;
            eol3_q <= 1'b0;
            v4_q   <= 1'b0;
            sof4_q <= 1'b0;
            eol4_q <= 1'b0;
        end else if (clken) begin
            v3_q   <= v2_q;
            sof3_q <= sof2_q;
            eol3_q <= eol2_q;
            v4_q   <= v3_q;
            sof4_q <= sof3_q;
            eol4_q <= eol3_q;
        end
    end

    logic [PW-1:0] dout_w;

    always_comb begin
        dout_w = '0;
        for (int ch = 0; ch < NCH; ch++)
            dout_w[ch*DW +: DW] = med[ch];
    end

    assign s.out_valid = v4_q;
    assign s.out_sof   = sof4_q;
    assign s.out_eol   = eol4_q;
    assign s.dout      = dout_w;
endmodule
